// File: rtl/glb_pkg.sv
// Shared widths, bank geometry, FSM encoding and saturation bounds for the GLB writeback path.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package glb_pkg;
    localparam int FIFO_DATA_WIDTH = 8;
    localparam int PSUM_WIDTH      = 32;
    localparam int PE_SIZE         = 16;
    localparam int MEM1_DEPTH      = 896;
    localparam int MEM1_ADDR_WIDTH = 10;
    localparam int MEM1_DATA_WIDTH = 128;
    localparam int SHIFT_WIDTH     = 5;
    localparam int CNT_WIDTH       = MEM1_ADDR_WIDTH + 1;

    localparam int SAT_MAX = (1 << (FIFO_DATA_WIDTH - 1)) - 1;
    localparam int SAT_MIN = -(1 << (FIFO_DATA_WIDTH - 1));

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } wb_state_t;
endpackage

// File: rtl/glb_writeback_psum_quant.sv
// One-lane quantiser: arithmetic right shift, then saturate to a signed FIFO_DATA_WIDTH value.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
module psum_quant
    import glb_pkg::*;
(
    input  logic signed [PSUM_WIDTH-1:0]      psum,
    input  logic        [SHIFT_WIDTH-1:0]     shift,
    output logic        [FIFO_DATA_WIDTH-1:0] q
);
    localparam logic signed [PSUM_WIDTH-1:0] HI = PSUM_WIDTH'(SAT_MAX);
    localparam logic signed [PSUM_WIDTH-1:0] LO = PSUM_WIDTH'(SAT_MIN);

    logic signed [PSUM_WIDTH-1:0] shifted;

    always_comb begin
        shifted = psum >>> shift;
        if (shifted > HI) begin
            q = HI[FIFO_DATA_WIDTH-1:0];
        end else if (shifted < LO) begin
            q = LO[FIFO_DATA_WIDTH-1:0];
        end else begin
            q = shifted[FIFO_DATA_WIDTH-1:0];
        end
    end
endmodule

// File: rtl/glb_writeback.sv
// Quantises accepted PE psum rows and writes them to consecutive (wrapping) MEM1 addresses.
// Latency: row accepted in cycle N is presented on the SRAM port-0 write signals in cycle N+1.
// Backpressure: psum_ready_o depends only on state/count; a held valid row waits without loss.
module glb_writeback
    import glb_pkg::*;
(
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             start_i,
    input  logic [MEM1_ADDR_WIDTH-1:0]       base_addr_i,
    input  logic [MEM1_ADDR_WIDTH-1:0]       num_words_i,
    input  logic [SHIFT_WIDTH-1:0]           shift_i,
    input  logic [PE_SIZE*PSUM_WIDTH-1:0]    psum_i,
    input  logic                             psum_valid_i,
    output logic                             psum_ready_o,
    output logic                             mem_ce_o,
    output logic                             mem_we_o,
    output logic [MEM1_ADDR_WIDTH-1:0]       mem_addr_o,
    output logic [MEM1_DATA_WIDTH-1:0]       mem_d_o,
    output logic                             busy_o,
    output logic                             done_o
);
    localparam logic [MEM1_ADDR_WIDTH-1:0] DEPTH_A   = MEM1_ADDR_WIDTH'(MEM1_DEPTH);
    localparam logic [MEM1_ADDR_WIDTH-1:0] LAST_ADDR = MEM1_ADDR_WIDTH'(MEM1_DEPTH - 1);

    generate
        if (MEM1_DATA_WIDTH != PE_SIZE * FIFO_DATA_WIDTH) begin : g_width_check
            $error("glb_writeback: MEM1_DATA_WIDTH must equal PE_SIZE*FIFO_DATA_WIDTH");
        end
    endgenerate

    wb_state_t                     state;
    logic [CNT_WIDTH-1:0]          acc_cnt;
    logic [CNT_WIDTH-1:0]          num_q;
    logic [MEM1_ADDR_WIDTH-1:0]    wr_addr;
    logic [SHIFT_WIDTH-1:0]        shift_q;
    logic [MEM1_DATA_WIDTH-1:0]    quant_row;
    logic [MEM1_ADDR_WIDTH-1:0]    base_mod;
    logic                          accept;

    assign psum_ready_o = (state == ST_RUN) && (acc_cnt != num_q);
    assign accept       = psum_ready_o && psum_valid_i;
    // Address width only reaches 2*DEPTH, so one conditional subtract is a full modulo.
    assign base_mod     = (base_addr_i >= DEPTH_A) ? (base_addr_i - DEPTH_A) : base_addr_i;

    for (genvar g = 0; g < PE_SIZE; g++) begin : g_lane
        psum_quant u_quant (
            .psum  (psum_i[PSUM_WIDTH*g +: PSUM_WIDTH]),
            .shift (shift_q),
            .q     (quant_row[FIFO_DATA_WIDTH*g +: FIFO_DATA_WIDTH])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            acc_cnt    <= '0;
            num_q      <= '0;
            wr_addr    <= '0;
            shift_q    <= '0;
            mem_ce_o   <= 1'b0;
            mem_we_o   <= 1'b0;
            mem_addr_o <= '0;
            mem_d_o    <= '0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
        end else begin
            mem_ce_o <= 1'b0;
            mem_we_o <= 1'b0;
            done_o   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start_i) begin
                        wr_addr <= base_mod;
                        num_q   <= {1'b0, num_words_i};
                        shift_q <= shift_i;
                        acc_cnt <= '0;
                        if (num_words_i != '0) begin
                            state  <= ST_RUN;
                            busy_o <= 1'b1;
                        end else begin
                            state  <= ST_DONE;
                            done_o <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (accept) begin
                        mem_ce_o   <= 1'b1;
                        mem_we_o   <= 1'b1;
                        mem_addr_o <= wr_addr;
                        mem_d_o    <= quant_row;
                        wr_addr    <= (wr_addr == LAST_ADDR) ? '0 : wr_addr + 1'b1;
                        acc_cnt    <= acc_cnt + 1'b1;
                        if ((acc_cnt + 1'b1) == num_q) begin
                            state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    // The final write is on the port this cycle; completion is signalled next.
                    state  <= ST_DONE;
                    busy_o <= 1'b0;
                    done_o <= 1'b1;
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_glb_writeback.sv
// Randomised and directed bench for glb_writeback with an in-bench transfer model.
module tb_glb_writeback;
    localparam int AW = 10;
    localparam int LANES = 16;
    localparam int PW = 32;
    localparam int QW = 8;
    localparam int DW = 128;
    localparam int DEPTH = 896;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start_i = 1'b0;
    logic [AW-1:0]     base_addr_i = '0;
    logic [AW-1:0]     num_words_i = '0;
    logic [4:0]        shift_i = '0;
    logic [LANES*PW-1:0] psum_i = '0;
    logic              psum_valid_i = 1'b0;
    logic              psum_ready_o;
    logic              mem_ce_o;
    logic              mem_we_o;
    logic [AW-1:0]     mem_addr_o;
    logic [DW-1:0]     mem_d_o;
    logic              busy_o;
    logic              done_o;

    always #5 clk = ~clk;

    glb_writeback dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_i      (start_i),
        .base_addr_i  (base_addr_i),
        .num_words_i  (num_words_i),
        .shift_i      (shift_i),
        .psum_i       (psum_i),
        .psum_valid_i (psum_valid_i),
        .psum_ready_o (psum_ready_o),
        .mem_ce_o     (mem_ce_o),
        .mem_we_o     (mem_we_o),
        .mem_addr_o   (mem_addr_o),
        .mem_d_o      (mem_d_o),
        .busy_o       (busy_o),
        .done_o       (done_o)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: shift as a 64-bit integer, then clamp to the signed 8-bit range.
    function automatic logic [QW-1:0] mq(input logic [PW-1:0] lane, input int sh);
        longint v;
        v = longint'($signed(lane));
        v = v >>> sh;
        if (v > 127) return 8'h7f;
        if (v < -128) return 8'h80;
        return v[QW-1:0];
    endfunction

    function automatic logic [DW-1:0] mrow(input logic [LANES*PW-1:0] p, input int sh);
        logic [DW-1:0] r;
        for (int i = 0; i < LANES; i++) r[QW*i +: QW] = mq(p[PW*i +: PW], sh);
        return r;
    endfunction

    function automatic logic [LANES*PW-1:0] rand_row();
        logic [LANES*PW-1:0] r;
        for (int i = 0; i < LANES; i++) begin
            logic [PW-1:0] v;
            v = $urandom;
            v = PW'($signed(v) >>> $urandom_range(0, 31));
            r[PW*i +: PW] = v;
        end
        return r;
    endfunction

    // Transfer model: phase 0 waiting, 1 taking rows, 2 last write out, 3 completion cycle.
    int            m_phase = 0;
    int            m_base = 0, m_k = 0, m_left = 0, m_shift = 0;
    bit            e_ce = 0, e_busy = 0, e_done = 0;
    int            e_addr = 0;
    logic [DW-1:0] e_d = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = 0; m_base = 0; m_k = 0; m_left = 0; m_shift = 0;
            e_ce = 0; e_busy = 0; e_done = 0; e_addr = 0; e_d = '0;
        end else begin
            e_ce = 0;
            e_done = 0;
            case (m_phase)
                0: if (start_i) begin
                    m_base  = int'(base_addr_i) % DEPTH;
                    m_shift = int'(shift_i);
                    m_k     = 0;
                    m_left  = int'(num_words_i);
                    if (m_left == 0) begin
                        e_done = 1;
                        m_phase = 3;
                    end else begin
                        e_busy = 1;
                        m_phase = 1;
                    end
                end
                1: if (psum_valid_i) begin
                    e_ce   = 1;
                    e_addr = (m_base + m_k) % DEPTH;
                    e_d    = mrow(psum_i, m_shift);
                    m_k++;
                    m_left--;
                    if (m_left == 0) m_phase = 2;
                end
                2: begin
                    e_busy = 0;
                    e_done = 1;
                    m_phase = 3;
                end
                default: m_phase = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        chk("ready", psum_ready_o, (m_phase == 1 && m_left > 0));
        chk("ce", mem_ce_o, e_ce);
        chk("we", mem_we_o, e_ce);
        chk("addr", mem_addr_o, e_addr);
        chk("data", mem_d_o, e_d);
        chk("busy", busy_o, e_busy);
        chk("done", done_o, e_done);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int b, input int n, input int s);
        start_i = 1'b1;
        base_addr_i = AW'(b);
        num_words_i = AW'(n);
        shift_i = 5'(s);
        tick();
        start_i = 1'b0;
    endtask

    task automatic finish_xfer();
        bit seen;
        seen = 0;
        for (int i = 0; i < 8 && !seen; i++) begin
            if (done_o) seen = 1;
            else tick();
        end
        chk("done_seen", seen, 1);
        tick();
    endtask

    task automatic run_xfer(input int b, input int n, input int s, input int vpct, input bit poke);
        int acc, budget;
        bit pending, took;
        do_start(b, n, s);
        acc = 0; budget = 0; pending = 0;
        while (acc < n && budget < 5000) begin
            if (!pending) begin
                if ($urandom_range(1, 100) <= vpct) begin
                    psum_i = rand_row();
                    psum_valid_i = 1'b1;
                    pending = 1;
                end else begin
                    psum_valid_i = 1'b0;
                end
            end
            if (poke) begin
                start_i = ($urandom_range(0, 7) == 0);
                base_addr_i = AW'($urandom);
                num_words_i = AW'($urandom);
                shift_i = 5'($urandom);
            end
            took = psum_valid_i && psum_ready_o;
            tick();
            budget++;
            if (took) begin
                acc++;
                pending = 0;
            end
        end
        chk("rows_accepted", acc, n);
        psum_valid_i = 1'b0;
        start_i = 1'b0;
        finish_xfer();
    endtask

    initial begin
        #1_000_000;
        n_err++;
        $display("FAIL timeout: simulation did not complete");
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        logic [DW-1:0] er;
        int wa[4];
        bit vp[7];
        bit ece[6];
        int nwr;

        // Reset state
        tick(); tick();
        chk("rst_ready", psum_ready_o, 0);
        chk("rst_ce", mem_ce_o, 0);
        chk("rst_addr", mem_addr_o, 0);
        chk("rst_data", mem_d_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        rst_n = 1'b1;
        tick();

        // Basic transfer: lane i = i, valid held high
        do_start(0, 4, 0);
        chk("t2_busy", busy_o, 1);
        chk("t2_no_early_write", mem_ce_o, 0);
        for (int i = 0; i < LANES; i++) begin
            psum_i[PW*i +: PW] = PW'(i);
            er[QW*i +: QW] = QW'(i);
        end
        psum_valid_i = 1'b1;
        for (int j = 0; j < 4; j++) begin
            tick();
            chk("t2_ce", mem_ce_o, 1);
            chk("t2_addr", mem_addr_o, j);
            chk("t2_data", mem_d_o, er);
        end
        psum_valid_i = 1'b0;
        tick();
        chk("t2_done", done_o, 1);
        chk("t2_busy_fall", busy_o, 0);
        chk("t2_ce_off", mem_ce_o, 0);
        tick();
        chk("t2_done_pulse", done_o, 0);

        // Saturation
        do_start(10, 1, 0);
        psum_i = '0;
        psum_i[PW*0 +: PW] = PW'(300);
        psum_i[PW*1 +: PW] = PW'(-300);
        psum_i[PW*2 +: PW] = PW'(127);
        psum_i[PW*3 +: PW] = PW'(-128);
        psum_i[PW*4 +: PW] = PW'(-1);
        psum_valid_i = 1'b1;
        tick();
        psum_valid_i = 1'b0;
        chk("t3_sat_pos", mem_d_o[QW*0 +: QW], 8'h7f);
        chk("t3_sat_neg", mem_d_o[QW*1 +: QW], 8'h80);
        chk("t3_max", mem_d_o[QW*2 +: QW], 8'h7f);
        chk("t3_min", mem_d_o[QW*3 +: QW], 8'h80);
        chk("t3_m1", mem_d_o[QW*4 +: QW], 8'hff);
        finish_xfer();
        do_start(20, 1, 4);
        psum_i = '0;
        psum_i[PW*0 +: PW] = PW'(1024);
        psum_i[PW*1 +: PW] = PW'(-1024);
        psum_i[PW*2 +: PW] = PW'(5000);
        psum_valid_i = 1'b1;
        tick();
        psum_valid_i = 1'b0;
        chk("t3_shift_pos", mem_d_o[QW*0 +: QW], 8'd64);
        chk("t3_shift_neg", mem_d_o[QW*1 +: QW], 8'hc0);
        chk("t3_shift_sat", mem_d_o[QW*2 +: QW], 8'h7f);
        finish_xfer();

        // Address wrap
        wa = '{894, 895, 0, 1};
        do_start(894, 4, 0);
        psum_valid_i = 1'b1;
        for (int j = 0; j < 4; j++) begin
            psum_i = rand_row();
            tick();
            chk("t4_wrap_addr", mem_addr_o, wa[j]);
        end
        psum_valid_i = 1'b0;
        finish_xfer();

        // Backpressure bubbles
        vp = '{1, 0, 1, 1, 0, 1, 1};
        ece = '{1, 0, 1, 1, 0, 1};
        nwr = 0;
        do_start(50, 4, 0);
        for (int j = 0; j < 6; j++) begin
            psum_valid_i = vp[j];
            psum_i = rand_row();
            tick();
            chk("t5_ce", mem_ce_o, ece[j]);
            if (mem_ce_o) begin
                chk("t5_addr", mem_addr_o, 50 + nwr);
                nwr++;
            end
        end
        psum_valid_i = vp[6];
        chk("t5_ready_after_last", psum_ready_o, 0);
        tick();
        chk("t5_no_extra_write", mem_ce_o, 0);
        chk("t5_done", done_o, 1);
        chk("t5_write_count", nwr, 4);
        psum_valid_i = 1'b0;
        tick();

        // Zero-length transfer; start in DONE ignored
        do_start(7, 0, 0);
        chk("t6_zero_done", done_o, 1);
        chk("t6_zero_busy", busy_o, 0);
        chk("t6_zero_ce", mem_ce_o, 0);
        start_i = 1'b1;
        num_words_i = AW'(2);
        tick();
        start_i = 1'b0;
        chk("t6_done_pulse", done_o, 0);
        chk("t6_start_in_done_ignored", busy_o, 0);
        tick();

        // Start during RUN ignored
        do_start(100, 3, 0);
        start_i = 1'b1;
        base_addr_i = AW'(500);
        num_words_i = AW'(1);
        tick();
        start_i = 1'b0;
        psum_valid_i = 1'b1;
        psum_i = rand_row();
        tick();
        chk("t6_run_start_addr", mem_addr_o, 100);
        tick();
        tick();
        chk("t6_run_start_count", mem_addr_o, 102);
        psum_valid_i = 1'b0;
        finish_xfer();

        // Asynchronous reset in the middle of a transfer
        do_start(5, 6, 0);
        psum_valid_i = 1'b1;
        psum_i = rand_row();
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("t1_async_ce", mem_ce_o, 0);
        chk("t1_async_we", mem_we_o, 0);
        chk("t1_async_ready", psum_ready_o, 0);
        chk("t1_async_busy", busy_o, 0);
        @(posedge clk);
        #1;
        psum_valid_i = 1'b0;
        rst_n = 1'b1;
        tick();

        // Randomised transfers, including base >= depth and a full-bank wrap
        for (int t = 0; t < 25; t++) begin
            run_xfer($urandom_range(0, 1023),
                     ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 12),
                     $urandom_range(0, 31), $urandom_range(30, 100), 1'b1);
        end
        run_xfer(1000, 900, 3, 100, 1'b0);
        run_xfer(895, 5, 0, 60, 1'b1);
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
